pc_if_stage: RTL and testbench
==============================

Name: pc_if_stage

Overview:
- Fetch stage of the 5-stage MIPS pipeline: program counter register, next-PC selection and the IF/ID pipeline register.
- Directly consumes the ID-stage branch-decision bit (br) and the decoded next-PC operation, and redirects fetch.
- Branches and jumps are resolved in ID with one architectural delay slot; the delay-slot instruction is never flushed.
- Feeds instruction memory (pc) and the ID stage (id_instr, id_pc, id_pc8).

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, IF/ID instruction value after reset (sll $0,$0,0).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- stall  input  1  from hazard unit; 1 = hold PC and IF/ID
- npc_op  input  2  from ID decoder: 00 seq, 01 branch, 10 j/jal, 11 jr/jalr
- br  input  1  branch condition from ID comparator; meaningful only when npc_op=01
- imm16  input  16  branch offset field of the ID instruction
- instr_index  input  26  jump target field of the ID instruction
- jr_target  input  32  forwarded rs value for jr/jalr
- im_instr  input  32  instruction word returned by instruction memory for pc (combinational read)
- pc  output  32  current fetch address to instruction memory
- id_instr  output  32  IF/ID instruction register
- id_pc  output  32  IF/ID PC register (address of id_instr)
- id_pc8  output  32  id_pc + 8, link address for jal/jalr

Behaviour:
- Reset (reset=0, asynchronous, any time including mid-stall or mid-redirect):
  - pc = RESET_PC, id_instr = NOP_INSTR, id_pc = 0.
  - id_pc8 follows id_pc (8 after reset).
  - First rising edge after release loads pc = RESET_PC+4 and id_instr = word at RESET_PC.
- Next-PC selection (combinational, all arithmetic modulo 2^32; no overflow detection):
  - seq, or branch with br=0: npc = pc + 4.
  - branch with br=1: npc = id_pc + 4 + (sign_extend(imm16) << 2).
  - j/jal: npc = {(id_pc + 4)[31:28], instr_index, 2'b00}.
  - jr/jalr: npc = jr_target, unmodified; no alignment check, low bits passed through.
  - br is ignored for npc_op other than 01.
- Rising edge, stall=0:
  - pc <= npc; id_instr <= im_instr; id_pc <= pc.
  - Redirect latency: the instruction after the branch (the delay slot) is fetched in the same cycle the branch sits in ID; the target is fetched in the following cycle.
- Rising edge, stall=1:
  - pc, id_instr and id_pc hold; npc is discarded.
  - A redirect pending during a stall is not remembered: the ID instruction stays, re-evaluates with updated forwarded operands, and redirects on the first non-stalled edge.
- Stall has priority over every redirect.
- No flush input: the delay-slot instruction always enters ID.
- id_pc8 is purely combinational: id_pc + 8.
- Single clock domain. No X propagation from im_instr into pc.

Decomposition:
- Shared package holds:
  - NPC_SEQ / NPC_BR / NPC_J / NPC_JR 2-bit encodings, shared with the ID decoder.
  - RESET_PC and NOP_INSTR constants.
- One natural sub-module: npc_calc, purely combinational (inputs pc, id_pc, npc_op, br, imm16, instr_index, jr_target; output npc).
- The PC register and the IF/ID register stay in pc_if_stage.

Test Plan:
- Reset/sequential:
  - Stimulus: hold reset=0, release, 3 edges with npc_op=00, stall=0.
  - Required: pc 3000→3004→3008→300C; id_pc 0→3000→3004→3008; id_instr tracks im_instr one cycle later.
- Taken backward branch:
  - Stimulus: id_pc=0x3010, npc_op=01, br=1, imm16=0xFFFC.
  - Required: next pc = 0x3004; delay slot at 0x3014 reaches ID.
  - Same with br=0: pc = old pc + 4.
- Jump/jr:
  - Stimulus: id_pc=0x3020, npc_op=10, instr_index=0x0000C40.
  - Required: pc=0x00003100; id_pc8 = 0x3028.
  - Stimulus: npc_op=11, jr_target=0x0000_3abc.
  - Required: pc=0x3abc.
- Stall with pending branch:
  - Stimulus: stall=1 for 2 edges while npc_op=01, br=1.
  - Required: pc/id_instr/id_pc unchanged.
  - Then stall=0: redirect to the branch target on that edge.
- Wrap-around:
  - Stimulus: pc=0xFFFF_FFFC, seq.
  - Required: pc=0x0000_0000.
  - Stimulus: id_pc=0x0000_0000, branch imm16=0x8000, br=1.
  - Required: pc=0xFFFE_0004.
- Asynchronous reset mid-stall:
  - Stimulus: assert reset=0 between edges while stall=1.
  - Required: pc=RESET_PC and id_instr=0 immediately, without a clock edge.

Source files
------------

// File: rtl/pc_if_stage_pkg.sv
// Shared definitions for the fetch stage: next-PC operation encodings
// (also used by the ID decoder) and reset constants.
package pc_if_stage_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_op_e;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  // Branch offset: sign-extended word offset converted to a byte offset.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/pc_if_stage_npc_calc.sv
// Combinational next-PC selection. Branch and jump targets are formed
// relative to the ID-stage instruction (the delay slot is already in flight).
module npc_calc
  import pc_if_stage_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] id_pc,
  input  logic [1:0]  npc_op,
  input  logic        br,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] jr_target,
  output logic [31:0] npc
);

  logic [31:0] seq_pc;
  logic [31:0] id_pc4;

  assign seq_pc = pc + 32'd4;
  assign id_pc4 = id_pc + 32'd4;

  always_comb begin
    npc = seq_pc;
    unique case (npc_op_e'(npc_op))
      NPC_SEQ: npc = seq_pc;
      NPC_BR:  npc = br ? (id_pc4 + branch_offset(imm16)) : seq_pc;
      NPC_J:   npc = {id_pc4[31:28], instr_index, 2'b00};
      NPC_JR:  npc = jr_target;
      default: npc = seq_pc;
    endcase
  end

endmodule

// File: rtl/pc_if_stage.sv
// MIPS fetch stage: program counter register, next-PC selection and the
// IF/ID pipeline register. Stall freezes both registers and drops any redirect.
module pc_if_stage
  import pc_if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_op,
  input  logic        br,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] jr_target,
  input  logic [31:0] im_instr,
  output logic [31:0] pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8
);

  logic [31:0] npc;

  npc_calc u_npc_calc (
    .pc          (pc),
    .id_pc       (id_pc),
    .npc_op      (npc_op),
    .br          (br),
    .imm16       (imm16),
    .instr_index (instr_index),
    .jr_target   (jr_target),
    .npc         (npc)
  );

  // A redirect seen during a stall is not stored; the held ID instruction
  // re-evaluates and redirects on the first non-stalled edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_PC;
      id_instr <= NOP_INSTR;
      id_pc    <= 32'h0000_0000;
    end else if (!stall) begin
      pc       <= npc;
      id_instr <= im_instr;
      id_pc    <= pc;
    end
  end

  assign id_pc8 = id_pc + 32'd8;

endmodule

// File: tb/tb_pc_if_stage.sv
// Scoreboard bench for pc_if_stage: an independent model pushes expected
// register state per driven cycle, which is popped and compared after the edge.
module tb_pc_if_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [1:0]  npc_op;
  logic        br;
  logic [15:0] imm16;
  logic [25:0] instr_index;
  logic [31:0] jr_target;
  logic [31:0] im_instr;
  logic [31:0] pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
  } exp_t;

  exp_t sb[$];

  logic [31:0] m_pc;
  logic [31:0] m_id_pc;
  logic [31:0] m_id_instr;

  int cnt_compared;
  int cnt_mismatched;

  pc_if_stage dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .npc_op      (npc_op),
    .br          (br),
    .imm16       (imm16),
    .instr_index (instr_index),
    .jr_target   (jr_target),
    .im_instr    (im_instr),
    .pc          (pc),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc8      (id_pc8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: a distinct word per address.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  assign im_instr = imem(pc);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    cnt_compared++;
    if (got !== want) begin
      cnt_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_pc       = 32'h0000_3000;
    m_id_pc    = 32'h0000_0000;
    m_id_instr = 32'h0000_0000;
  endtask

  // Drive one cycle of inputs, predict the post-edge state, then compare.
  task automatic applyStimulus(input logic s, input logic [1:0] op, input logic b,
                               input logic [15:0] i16, input logic [25:0] idx,
                               input logic [31:0] jt);
    logic signed [31:0] off;
    logic [31:0] nxt;
    exp_t e;
    exp_t g;
    stall       = s;
    npc_op      = op;
    br          = b;
    imm16       = i16;
    instr_index = idx;
    jr_target   = jt;
    off = 32'($signed(i16));
    off = off * 4;
    case (op)
      2'd1:    nxt = b ? (m_id_pc + 32'd4 + off) : (m_pc + 32'd4);
      2'd2:    nxt = ((m_id_pc + 32'd4) & 32'hF000_0000) | (32'(idx) << 2);
      2'd3:    nxt = jt;
      default: nxt = m_pc + 32'd4;
    endcase
    if (!s) begin
      m_id_instr = imem(m_pc);
      m_id_pc    = m_pc;
      m_pc       = nxt;
    end
    e.pc = m_pc;
    e.id_pc = m_id_pc;
    e.id_instr = m_id_instr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    checkOutput("pc", pc, g.pc);
    checkOutput("id_pc", id_pc, g.id_pc);
    checkOutput("id_instr", id_instr, g.id_instr);
    checkOutput("id_pc8", id_pc8, g.id_pc + 32'd8);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cnt_compared   = 0;
    cnt_mismatched = 0;
    stall = 1'b0; npc_op = 2'd0; br = 1'b0; imm16 = '0; instr_index = '0; jr_target = '0;
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checkOutput("reset_pc", pc, 32'h0000_3000);
    checkOutput("reset_id_instr", id_instr, 32'h0000_0000);
    checkOutput("reset_id_pc", id_pc, 32'h0000_0000);
    checkOutput("reset_id_pc8", id_pc8, 32'h0000_0008);
    reset = 1'b1;

    // Sequential fetch after reset
    repeat (3) applyStimulus(1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
    checkOutput("seq_pc_300c", pc, 32'h0000_300C);

    // Taken backward branch from 0x3010; delay slot 0x3014 enters ID
    applyStimulus(1'b0, 2'd3, 1'b0, 16'h0, 26'h0, 32'h0000_3010);
    applyStimulus(1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
    applyStimulus(1'b0, 2'd1, 1'b1, 16'hFFFC, 26'h0, 32'h0);
    checkOutput("br_taken_pc", pc, 32'h0000_3004);
    checkOutput("br_delay_slot", id_pc, 32'h0000_3014);
    // Not-taken branch; br ignored for seq
    applyStimulus(1'b0, 2'd1, 1'b0, 16'hFFFC, 26'h0, 32'h0);
    applyStimulus(1'b0, 2'd0, 1'b1, 16'hFFFC, 26'h0, 32'h0);

    // Jump from id_pc 0x3020
    applyStimulus(1'b0, 2'd3, 1'b0, 16'h0, 26'h0, 32'h0000_3020);
    applyStimulus(1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
    checkOutput("j_id_pc8", id_pc8, 32'h0000_3028);
    applyStimulus(1'b0, 2'd2, 1'b1, 16'h0, 26'h0000C40, 32'h0);
    checkOutput("j_pc", pc, 32'h0000_3100);
    applyStimulus(1'b0, 2'd3, 1'b0, 16'h0, 26'h0, 32'h0000_3ABC);
    checkOutput("jr_pc", pc, 32'h0000_3ABC);
    applyStimulus(1'b0, 2'd3, 1'b0, 16'h0, 26'h0, 32'h0000_3013);

    // Stall with pending taken branch, then release
    applyStimulus(1'b0, 2'd3, 1'b0, 16'h0, 26'h0, 32'h0000_3200);
    applyStimulus(1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
    applyStimulus(1'b1, 2'd1, 1'b1, 16'h0010, 26'h0, 32'h0);
    applyStimulus(1'b1, 2'd1, 1'b1, 16'h0010, 26'h0, 32'h0);
    checkOutput("stall_hold_pc", pc, 32'h0000_3204);
    applyStimulus(1'b0, 2'd1, 1'b1, 16'h0010, 26'h0, 32'h0);
    checkOutput("stall_release_pc", pc, 32'h0000_3244);

    // Wrap-around cases
    applyStimulus(1'b0, 2'd3, 1'b0, 16'h0, 26'h0, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
    checkOutput("wrap_seq_pc", pc, 32'h0000_0000);
    applyStimulus(1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
    applyStimulus(1'b0, 2'd1, 1'b1, 16'h8000, 26'h0, 32'h0);
    checkOutput("wrap_br_pc", pc, 32'hFFFE_0004);

    // Random mix
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    16'($urandom), 26'($urandom), $urandom);
    end

    // Asynchronous reset between edges while stalled
    stall = 1'b1;
    #3;
    reset = 1'b0;
    #1;
    checkOutput("async_reset_pc", pc, 32'h0000_3000);
    checkOutput("async_reset_id_instr", id_instr, 32'h0000_0000);
    checkOutput("async_reset_id_pc", id_pc, 32'h0000_0000);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) applyStimulus(1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt_compared, cnt_mismatched);
    $finish;
  end

endmodule
